hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
// - Consumer end of the decoder's Tuse/Tnew hazard interface: tracks in-flight register writes through E/M/W.
// - Compares them against the D-stage instruction's source registers and produces stall, flush and forwarding selects.
// - Sits beside the 5-stage MIPS pipeline; drives PC/D enables, E flush and all bypass muxes.
// PARAMETERS
// - MULT_CYCLES  5   MDU busy cycles after mult/multu leaves E (only with HAZARD_MDU_STALL_EN)
// - DIV_CYCLES   10  MDU busy cycles after div/divu leaves E (only with HAZARD_MDU_STALL_EN)
// - CNT_W        4   MDU busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES)
// PORTS
// - clk         in   1  rising-edge clock
// - reset       in   1  synchronous, active-low reset
// - d_use_a/b   in   1  D instr reads rs/rt
// - d_rs/d_rt   in   5  D source registers
// - d_tuse_a/b  in   2  cycles until rs/rt needed, from D; 2'b11 = never
// - d_rw        in   1  D instr writes GPR
// - d_wreg      in   5  D destination register
// - d_tnew      in   2  cycles from D until result exists (ALU=2, load=3, link=0)
// - d_md        in   1  D instr touches MDU (mult/div/mfhi/mflo/mthi/mtlo)
// - d_md_start  in   1  D instr starts the MDU
// - d_md_div    in   1  started op is a divide
// - stall       out  1  freeze PC and D register
// - e_flush     out  1  insert bubble into E; always equal to stall
// - fwd_d_a/b   out  2  D operand source: 00 RF, 01 E, 10 M, 11 W
// - fwd_e_a/b   out  2  E operand source: 00 pipe reg, 10 M, 11 W
// - fwd_m_b     out  1  M store-data source: 0 pipe reg, 1 W
// - md_busy     out  1  MDU busy counter nonzero
// BEHAVIOUR
// - Per-stage tracking regs {rw, wreg, tnew, rs, rt, use_a, use_b} for E, M, W; E also holds md_start and md_div.
// - Every edge when stall=0:
//   - E <= D fields with tnew = sat_dec(d_tnew).
//   - M <= E with tnew = sat_dec(tnew_e); W <= M with tnew = sat_dec(tnew_m).
// - Every edge when stall=1: E <= bubble (rw=0, tnew=0, use=0, md_start=0); M and W advance normally.
// - sat_dec(x) = (x==0) ? 0 : x-1. Tnew never wraps.
// - Match(S, r) = S.rw && S.wreg==r && r!=0. Register $0 never stalls and never forwards.
// - stall_a = d_use_a && (Match(E,rs) && tnew_e>d_tuse_a || Match(M,rs) && tnew_m>d_tuse_a); stall_b is identical on rt.
// - stall = stall_a | stall_b | md_stall. W is never a stall source.
// - fwd_d_x picks the youngest match with tnew==0, priority E > M > W; otherwise 00.
// - A younger match with tnew>0 shadows older stages; it yields 00 (stall covers it).
// - fwd_e_x: M (tnew_m==0) has priority over W; only asserted when E.use_x is set.
// - fwd_m_b = Match(W, M.rt) && M.use_b.
// - All outputs are combinational from the tracking regs plus D inputs; no output latency beyond that.
// - Reset (low at an edge, including mid-operation):
//   - All stage regs are cleared to bubble and the MDU counter is cleared.
//   - Next cycle: stall=0, e_flush=0, all fwd=0, md_busy=0.
// CONFIGURATION
// - HAZARD_MDU_STALL_EN defined:
//   - When E leaves with md_start, the counter loads MULT_CYCLES or DIV_CYCLES, then decrements to 0.
//   - md_busy = (cnt!=0).
//   - md_stall = d_md && (md_busy || E.md_start).
//   - A second start while busy is impossible because it is stalled.
// - HAZARD_MDU_STALL_EN undefined: no counter; md_stall=0, md_busy=0; d_md* ignored.
// STRUCTURE
// - Shared macro.v constants: TUSE_NEVER=2'b11; FWD_RF/FWD_E/FWD_M/FWD_W encodings.
// - Sub-module hazard_mdu_timer: load/decrement counter, instantiated only under HAZARD_MDU_STALL_EN.
// TESTING
// - lw $8 in E (tnew_e=2); D addu rs=$8, tuse=1:
//   - stall=1 for exactly 1 cycle.
//   - When addu is in E (lw in W): fwd_e_a=11.
// - addu $9 in E (tnew_e=1); D beq rs=$9, tuse=0 -> stall 1 cycle, then fwd_d_a=10.
// - jal in E (wreg=31, tnew_e=0); D jr $31 -> stall=0, fwd_d_a=01.
// - Writer to $0 in E with load timing; D reads $0 -> stall=0, all fwd=00.
// - $10 written by both E (tnew 0) and M -> fwd_d_a=01.
// - Reset low while lw is in E -> next cycle stall=0.
// - With HAZARD_MDU_STALL_EN: mult then mfhi -> stall for MULT_CYCLES+1 cycles; md_busy high for MULT_CYCLES.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared hazard-unit types: forwarding encodings, per-stage tracking record and match helpers.
package hazard_pkg;

    localparam logic [1:0] TUSE_NEVER = 2'b11;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_E  = 2'b01,
        FWD_M  = 2'b10,
        FWD_W  = 2'b11
    } fwd_t;

    typedef struct packed {
        logic       rw;
        logic [4:0] wreg;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_a;
        logic       use_b;
        logic       md_start;
        logic       md_div;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '0;

    function automatic logic [1:0] sat_dec(input logic [1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

    // $0 is hardwired, so a write to it never matches a reader.
    function automatic logic match(input stage_t s, input logic [4:0] r);
        return s.rw && (s.wreg == r) && (r != 5'd0);
    endfunction

    function automatic logic raw_stall(input stage_t e, input stage_t m, input logic use_x,
                                       input logic [4:0] r, input logic [1:0] tuse);
        return use_x && (tuse != TUSE_NEVER) &&
               ((match(e, r) && (e.tnew > tuse)) || (match(m, r) && (m.tnew > tuse)));
    endfunction

    // The youngest writer wins; if its result is not ready the stall covers it.
    function automatic fwd_t fwd_d_sel(input stage_t e, input stage_t m, input stage_t w,
                                       input logic [4:0] r);
        if (match(e, r))      return (e.tnew == 2'd0) ? FWD_E : FWD_RF;
        else if (match(m, r)) return (m.tnew == 2'd0) ? FWD_M : FWD_RF;
        else if (match(w, r)) return (w.tnew == 2'd0) ? FWD_W : FWD_RF;
        else                  return FWD_RF;
    endfunction

    function automatic fwd_t fwd_e_sel(input stage_t m, input stage_t w, input logic use_x,
                                       input logic [4:0] r);
        if (!use_x)                              return FWD_RF;
        else if (match(m, r) && m.tnew == 2'd0)  return FWD_M;
        else if (match(w, r))                    return FWD_W;
        else                                     return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_mdu_timer.sv
// MDU busy counter: loads the op latency when a mult/div leaves E, then counts down to zero.
module hazard_mdu_timer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic div_i,
    output logic busy_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_unit.sv
// Tuse/Tnew hazard unit for the 5-stage MIPS pipeline: stall, E flush and bypass selects.
// Optional MDU interlock is enabled by defining HAZARD_MDU_STALL_EN.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_use_a,
    input  logic       d_use_b,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_a,
    input  logic [1:0] d_tuse_b,
    input  logic       d_rw,
    input  logic [4:0] d_wreg,
    input  logic [1:0] d_tnew,
    input  logic       d_md,
    input  logic       d_md_start,
    input  logic       d_md_div,
    output logic       stall,
    output logic       e_flush,
    output logic [1:0] fwd_d_a,
    output logic [1:0] fwd_d_b,
    output logic [1:0] fwd_e_a,
    output logic [1:0] fwd_e_b,
    output logic       fwd_m_b,
    output logic       md_busy
);

    stage_t e_q, m_q, w_q;
    stage_t e_d, m_d, w_d;
    logic   md_stall;

    assign stall   = raw_stall(e_q, m_q, d_use_a, d_rs, d_tuse_a) |
                     raw_stall(e_q, m_q, d_use_b, d_rt, d_tuse_b) | md_stall;
    assign e_flush = stall;

    assign fwd_d_a = fwd_d_sel(e_q, m_q, w_q, d_rs);
    assign fwd_d_b = fwd_d_sel(e_q, m_q, w_q, d_rt);
    assign fwd_e_a = fwd_e_sel(m_q, w_q, e_q.use_a, e_q.rs);
    assign fwd_e_b = fwd_e_sel(m_q, w_q, e_q.use_b, e_q.rt);
    assign fwd_m_b = match(w_q, m_q.rt) && m_q.use_b;

    always_comb begin
        e_d = STAGE_BUBBLE;
        if (!stall) begin
            e_d.rw       = d_rw;
            e_d.wreg     = d_wreg;
            e_d.tnew     = sat_dec(d_tnew);
            e_d.rs       = d_rs;
            e_d.rt       = d_rt;
            e_d.use_a    = d_use_a;
            e_d.use_b    = d_use_b;
            e_d.md_start = d_md_start;
            e_d.md_div   = d_md_div;
        end
        // M and W keep flowing during a stall so the blocking producer can retire.
        m_d      = e_q;
        m_d.tnew = sat_dec(e_q.tnew);
        w_d      = m_q;
        w_d.tnew = sat_dec(m_q.tnew);
    end

    // NOTE: state registers use non-blocking assignments so every stage samples the old values of its neighbours.
    always_ff @(posedge clk) begin
        if (!reset) begin
            e_q <= STAGE_BUBBLE;
            m_q <= STAGE_BUBBLE;
            w_q <= STAGE_BUBBLE;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

`ifdef HAZARD_MDU_STALL_EN
    logic md_busy_w;

    hazard_mdu_timer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_mdu_timer (
        .clk   (clk),
        .reset (reset),
        .load_i(e_q.md_start),
        .div_i (e_q.md_div),
        .busy_o(md_busy_w)
    );

    assign md_stall = d_md && (md_busy_w || e_q.md_start);
    assign md_busy  = md_busy_w;
`else
    logic [CNT_W-1:0] unused_params;
    assign unused_params = CNT_W'(MULT_CYCLES) ^ CNT_W'(DIV_CYCLES);
    assign md_stall = 1'b0;
    assign md_busy  = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{d_md, e_q.md_start, e_q.md_div, m_q.use_a, m_q.rs, m_q.md_start,
                           m_q.md_div, w_q.rs, w_q.rt, w_q.use_a, w_q.use_b, w_q.md_start,
                           w_q.md_div};

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table through a scoreboard plus reset and MDU sequences.
module tb_hazard_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic       clk;
    logic       reset;
    logic       d_use_a, d_use_b, d_rw, d_md, d_md_start, d_md_div;
    logic [4:0] d_rs, d_rt, d_wreg;
    logic [1:0] d_tuse_a, d_tuse_b, d_tnew;
    logic       stall, e_flush, fwd_m_b, md_busy;
    logic [1:0] fwd_d_a, fwd_d_b, fwd_e_a, fwd_e_b;

    hazard_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .d_use_a(d_use_a), .d_use_b(d_use_b), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_a(d_tuse_a), .d_tuse_b(d_tuse_b), .d_rw(d_rw), .d_wreg(d_wreg),
        .d_tnew(d_tnew), .d_md(d_md), .d_md_start(d_md_start), .d_md_div(d_md_div),
        .stall(stall), .e_flush(e_flush), .fwd_d_a(fwd_d_a), .fwd_d_b(fwd_d_b),
        .fwd_e_a(fwd_e_a), .fwd_e_b(fwd_e_b), .fwd_m_b(fwd_m_b), .md_busy(md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       use_a;
        logic [4:0] rs;
        logic [1:0] tuse_a;
        logic       use_b;
        logic [4:0] rt;
        logic [1:0] tuse_b;
        logic       rw;
        logic [4:0] wreg;
        logic [1:0] tnew;
        logic       md;
        logic       md_start;
        logic       md_div;
    } din_t;

    typedef struct packed {
        logic       stall;
        logic [1:0] fda;
        logic [1:0] fdb;
        logic [1:0] fea;
        logic [1:0] feb;
        logic       fmb;
    } exp_t;

    typedef struct packed {
        din_t d;
        exp_t e;
    } vec_t;

    int   total_cnt = 0;
    int   pass_cnt  = 0;
    exp_t sb[$];
    vec_t tbl[$];

    function automatic din_t di(input logic ua, input int rs, input int ta, input logic ub,
                                input int rt, input int tb, input logic rw, input int wr,
                                input int tn);
        din_t d;
        d.use_a = ua; d.rs = 5'(rs); d.tuse_a = 2'(ta);
        d.use_b = ub; d.rt = 5'(rt); d.tuse_b = 2'(tb);
        d.rw = rw; d.wreg = 5'(wr); d.tnew = 2'(tn);
        d.md = 1'b0; d.md_start = 1'b0; d.md_div = 1'b0;
        return d;
    endfunction

    function automatic exp_t ex(input logic s, input int fda, input int fdb, input int fea,
                                input int feb, input logic fmb);
        exp_t e;
        e.stall = s; e.fda = 2'(fda); e.fdb = 2'(fdb);
        e.fea = 2'(fea); e.feb = 2'(feb); e.fmb = fmb;
        return e;
    endfunction

    function automatic vec_t mk(input din_t d, input exp_t e);
        vec_t v;
        v.d = d; v.e = e;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int req);
        total_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic drive(input din_t d);
        d_use_a = d.use_a; d_rs = d.rs; d_tuse_a = d.tuse_a;
        d_use_b = d.use_b; d_rt = d.rt; d_tuse_b = d.tuse_b;
        d_rw = d.rw; d_wreg = d.wreg; d_tnew = d.tnew;
        d_md = d.md; d_md_start = d.md_start; d_md_div = d.md_div;
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, " stall"},   int'(stall),   int'(e.stall));
        check({tag, " e_flush"}, int'(e_flush), int'(e.stall));
        check({tag, " fwd_d_a"}, int'(fwd_d_a), int'(e.fda));
        check({tag, " fwd_d_b"}, int'(fwd_d_b), int'(e.fdb));
        check({tag, " fwd_e_a"}, int'(fwd_e_a), int'(e.fea));
        check({tag, " fwd_e_b"}, int'(fwd_e_b), int'(e.feb));
        check({tag, " fwd_m_b"}, int'(fwd_m_b), int'(e.fmb));
    endtask

    // Drive one D-stage instruction, sample on the falling edge, then let the rising edge commit it.
    task automatic step(input int idx, input vec_t v);
        exp_t e;
        drive(v.d);
        sb.push_back(v.e);
        @(negedge clk);
        e = sb.pop_front();
        check_outputs($sformatf("vec%0d", idx), e);
        check($sformatf("vec%0d md_busy", idx), int'(md_busy), 0);
        @(posedge clk); #1;
    endtask

    task automatic mdu_run(input string tag, input logic is_div, input int exp_stall,
                           input int exp_busy);
        din_t d;
        int   n_stall = 0;
        int   n_busy  = 0;
        logic done    = 1'b0;
        d = di(1, 1, 1, 1, 2, 1, 0, 0, 0);
        d.md = 1'b1; d.md_start = 1'b1; d.md_div = is_div;
        drive(d);
        @(negedge clk);
        check({tag, " start no stall"}, int'(stall), 0);
        @(posedge clk); #1;
        d = di(0, 0, 3, 0, 0, 3, 1, 15, 2);
        d.md = 1'b1;
        drive(d);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall)   n_stall++;
            if (md_busy) n_busy++;
            if (!stall) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, " released"},     int'(done),   1);
        check({tag, " stall cycles"}, n_stall,      exp_stall);
        check({tag, " busy cycles"},  n_busy,       exp_busy);
        check({tag, " busy after"},   int'(md_busy), 0);
        @(posedge clk); #1;
        drive(di(0, 0, 3, 0, 0, 3, 0, 0, 0));
        @(posedge clk); #1;
    endtask

    initial begin
        din_t nop;
        nop = di(0, 0, 3, 0, 0, 3, 0, 0, 0);

        // lw $8 then dependent addu: one stall cycle, later W->E bypass
        tbl.push_back(mk(di(1, 29, 1, 0, 0, 3, 1, 8, 3),  ex(0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(di(1, 8, 1, 1, 9, 1, 1, 11, 2),  ex(1, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(di(1, 8, 1, 1, 9, 1, 1, 11, 2),  ex(0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(nop,                              ex(0, 0, 0, 3, 0, 0)));
        tbl.push_back(mk(nop,                              ex(0, 0, 0, 0, 0, 0)));
        // addu $9 then beq on $9 with tuse 0
        tbl.push_back(mk(di(1, 1, 1, 1, 2, 1, 1, 9, 2),   ex(0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(di(1, 9, 0, 1, 0, 0, 0, 0, 0),   ex(1, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(di(1, 9, 0, 1, 0, 0, 0, 0, 0),   ex(0, 2, 0, 0, 0, 0)));
        // jal then jr $31
        tbl.push_back(mk(di(0, 0, 3, 0, 0, 3, 1, 31, 0),  ex(0, 0, 0, 3, 0, 0)));
        tbl.push_back(mk(di(1, 31, 0, 0, 0, 3, 0, 0, 0),  ex(0, 1, 0, 0, 0, 0)));
        // load to $0, then reader of $0
        tbl.push_back(mk(di(1, 29, 1, 0, 0, 3, 1, 0, 3),  ex(0, 0, 0, 2, 0, 0)));
        tbl.push_back(mk(di(1, 0, 1, 1, 0, 1, 1, 12, 2),  ex(0, 0, 0, 0, 0, 0)));
        // $10 written by both E and M; rt=$12 from W
        tbl.push_back(mk(di(1, 1, 1, 1, 2, 1, 1, 10, 2),  ex(0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(di(0, 0, 3, 0, 0, 3, 1, 10, 0),  ex(0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(di(1, 10, 1, 1, 12, 1, 0, 0, 0), ex(0, 1, 3, 0, 0, 0)));
        // lw $13 then store of $13: W->M store-data bypass
        tbl.push_back(mk(di(1, 1, 1, 0, 0, 3, 1, 13, 3),  ex(0, 0, 0, 2, 0, 0)));
        tbl.push_back(mk(di(1, 1, 1, 1, 13, 2, 0, 0, 0),  ex(0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(nop,                              ex(0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(nop,                              ex(0, 0, 0, 0, 0, 1)));
        // lw $14, gap, beq $14: stall from M, then W bypass
        tbl.push_back(mk(di(1, 1, 1, 0, 0, 3, 1, 14, 3),  ex(0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(nop,                              ex(0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(di(1, 14, 0, 1, 0, 0, 0, 0, 0),  ex(1, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(di(1, 14, 0, 1, 0, 0, 0, 0, 0),  ex(0, 3, 0, 0, 0, 0)));
        tbl.push_back(mk(nop,                              ex(0, 0, 0, 0, 0, 0)));

        reset = 1'b0;
        drive(di(1, 29, 1, 0, 0, 3, 1, 8, 3));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        drive(nop);
        @(negedge clk);
        check_outputs("reset", ex(0, 0, 0, 0, 0, 0));
        check("reset md_busy", int'(md_busy), 0);
        @(posedge clk); #1;

        foreach (tbl[i]) step(i, tbl[i]);

        // Reset asserted while a load sits in E with a dependent reader in D
        drive(di(1, 29, 1, 0, 0, 3, 1, 8, 3));
        @(posedge clk); #1;
        drive(di(1, 8, 1, 1, 9, 1, 1, 11, 2));
        @(negedge clk);
        check("pre-reset stall", int'(stall), 1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_outputs("midreset", ex(0, 0, 0, 0, 0, 0));
        check("midreset md_busy", int'(md_busy), 0);
        @(posedge clk); #1;
        drive(nop);
        @(posedge clk); #1;

`ifdef HAZARD_MDU_STALL_EN
        mdu_run("mult", 1'b0, MULT_CYCLES + 1, MULT_CYCLES);
        mdu_run("div",  1'b1, DIV_CYCLES + 1,  DIV_CYCLES);
`else
        mdu_run("mult", 1'b0, 0, 0);
        mdu_run("div",  1'b1, 0, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
